// File: rtl/ex_mem.sv
// EX/MEM pipeline register.
//
// Carries the EX-stage result (register-file write, HI/LO write) into the MEM
// stage with exactly one cycle of latency. It also holds the multiply-
// accumulate partial product and step counter that EX feeds back to itself
// while it is stalled on a multi-cycle MADD/MSUB sequence.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous active-low reset; clears every output
//   stall      in   stall bus; bit 3 = EX stalled, bit 4 = MEM stalled
//   ex_wreg    in   EX register-file write enable
//   ex_waddr   in   EX destination register address
//   ex_wdata   in   EX result data
//   ex_hi/lo   in   EX HI/LO write values
//   ex_whilo   in   EX HI/LO write enable
//   hilo_i     in   EX multiply-accumulate partial product
//   cnt_i      in   EX multi-cycle step counter
//   mem_*      out  registered copies of ex_* for the MEM stage
//   hilo_o     out  registered partial product fed back to EX
//   cnt_o      out  registered step counter fed back to EX
//
// Configuration:
//   EX_MEM_HILO_TEMP_EN  defined     -> hilo_o/cnt_o feedback registers exist
//                        not defined -> hilo_o/cnt_o tied to 0, hilo_i/cnt_i
//                                       ignored (port list unchanged)
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic        mem_wreg,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  typedef enum logic [1:0] {
    ModeAdvance,
    ModeBubble,
    ModeHold
  } mode_e;

  mode_e mode;

  // stall[3] alone decides Advance; the illegal 0/1 combination lands here too.
  always_comb begin
    mode = ModeAdvance;
    if (stall[3]) begin
      mode = stall[4] ? ModeHold : ModeBubble;
    end
  end

  // Only bits 3 and 4 of the stall bus are meaningful to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // MEM-side registers.
  logic        wreg_q,  wreg_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        whilo_q, whilo_d;

  always_comb begin
    wreg_d  = wreg_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    unique case (mode)
      ModeAdvance: begin
        wreg_d  = ex_wreg;
        waddr_d = ex_waddr;
        wdata_d = ex_wdata;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        whilo_d = ex_whilo;
      end
      ModeBubble: begin
        // Insert a NOP into MEM while EX is still working.
        wreg_d  = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = 1'b0;
      end
      default: ;  // ModeHold keeps everything
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
    end else begin
      wreg_q  <= wreg_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
    end
  end

  assign mem_wreg  = wreg_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;

`ifdef EX_MEM_HILO_TEMP_EN
  // Feedback registers: recaptured on every Bubble so the EX step counter
  // walks across consecutive stall cycles, and cleared on Advance so the
  // next EX instruction starts from step 0.
  logic [63:0] hilo_q, hilo_d;
  logic [1:0]  cnt_q,  cnt_d;

  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (mode)
      ModeAdvance: begin
        hilo_d = '0;
        cnt_d  = '0;
      end
      ModeBubble: begin
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`else
  logic unused_fb;
  assign unused_fb = ^{hilo_i, cnt_i};

  assign hilo_o = '0;
  assign cnt_o  = '0;
`endif

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
REQ-004 stall  in  6  pipeline stall bus; bit 3 = EX stage stalled, bit 4 = MEM stage stalled; other bits ignored.
REQ-005 ex_wreg  in  1  EX register-file write enable.
REQ-006 ex_waddr  in  5  EX destination register address.
REQ-007 ex_wdata  in  32  EX result data.
REQ-008 ex_hi, ex_lo  in  32 each  EX HI/LO write values.
REQ-009 ex_whilo  in  1  EX HI/LO write enable.
REQ-010 hilo_i  in  64  EX multiply-accumulate partial product (first cycle of MADD/MSUB family).
REQ-011 cnt_i  in  2  EX multi-cycle step counter.
REQ-012 mem_wreg, mem_waddr, mem_wdata, mem_hi, mem_lo, mem_whilo  out  1/5/32/32/32/1  registered copies to MEM stage.
REQ-013 hilo_o  out  64  registered partial product fed back to EX.
REQ-014 cnt_o  out  2  registered step counter fed back to EX.

Function
REQ-015 All outputs SHALL be registers; EX-to-MEM latency SHALL be exactly one clk cycle.
REQ-016 Advance (stall[3]==0): MEM-side outputs capture the ex_* inputs; hilo_o SHALL clear to 0; cnt_o SHALL clear to 2'b00.
REQ-017 Bubble (stall[3]==1, stall[4]==0): MEM-side outputs SHALL become zero (wreg=0, waddr=0, wdata=0, hi=0, lo=0, whilo=0); hilo_o captures hilo_i; cnt_o captures cnt_i.
REQ-018 Hold (stall[3]==1, stall[4]==1): all outputs, including hilo_o and cnt_o, SHALL keep their values.
REQ-019 stall[3]==0 with stall[4]==1 is illegal; the block SHALL treat it as Advance (stall[3] alone decides).
REQ-020 Repeated Bubble cycles SHALL re-capture hilo_i/cnt_i every cycle, so the EX counter sequence 00->01->10 is carried across consecutive stall cycles.
REQ-021 The first Advance after a Bubble SHALL clear hilo_o/cnt_o in the same edge that the completed result reaches MEM, so the next EX instruction starts with cnt_i==00.
REQ-022 No arithmetic is performed; all fields pass bit-exact at declared widths.

Reset
REQ-023 While rst==0 every output SHALL be 0 (mem_* = 0, hilo_o = 64'h0, cnt_o = 2'b00), asynchronously.
REQ-024 Reset during a multi-cycle sequence SHALL abort it: after rst returns high, cnt_o==00 until the next Bubble capture.
REQ-025 Rising rst SHALL take effect on the next clk edge with no spurious capture at release.

Configuration
REQ-026 Macro EX_MEM_HILO_TEMP_EN: defined -> hilo_o/cnt_o feedback registers exist and behave per REQ-016..021.
REQ-027 Not defined -> hilo_o and cnt_o SHALL be tied constant 0, hilo_i/cnt_i ignored; all other behaviour unchanged (port list identical).

Verification
REQ-028 Reset: drive rst=0 mid-cycle with ex_wdata=32'hDEADBEEF captured -> all outputs 0 immediately, before the next clk edge.
REQ-029 Pass-through: stall=0, ex_wreg=1, ex_waddr=5'd3, ex_wdata=32'h00001234 -> next edge mem_wreg=1, mem_waddr=3, mem_wdata=32'h1234, cnt_o=0.
REQ-030 Bubble: stall=6'b001111, ex_wreg=1, hilo_i=64'h0000_0001_0000_0002, cnt_i=2'b01 -> next edge mem_wreg=0, mem_wdata=0, hilo_o=64'h1_0000_0002, cnt_o=01.
REQ-031 MADD sequence: edge1 stall[3]=1, cnt_i=01; edge2 stall=0, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h5 -> after edge2 mem_whilo=1, mem_hi=1, mem_lo=5, cnt_o=00, hilo_o=0.
REQ-032 Hold: stall=6'b011111 for 3 cycles after REQ-029 state -> mem_wdata stays 32'h1234, cnt_o unchanged.
REQ-033 Macro off: repeat REQ-030 -> hilo_o=0, cnt_o=0; MEM-side outputs as in REQ-030.
